// File: rtl/des_cfg_pkg.sv
// Shared encodings and sizing for the S-box configuration loader.
// Table geometry, command modes and loader states live here.
package des_cfg_pkg;

  localparam int N_SBOX      = 8;
  localparam int N_ROW       = 4;
  localparam int N_COL       = 16;
  localparam int DW          = 4;
  localparam int ENTRIES_BOX = N_ROW * N_COL;
  localparam int ENTRIES_ALL = N_SBOX * ENTRIES_BOX;

  localparam int SW   = 3;
  localparam int RW   = 2;
  localparam int CW   = 4;
  localparam int CNTW = 10;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_BOX    = 2'd1,
    MODE_ALL    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Index of the final entry of a command; the entry counter is compared against it.
  function automatic logic [CNTW-1:0] last_index(input mode_t m);
    case (m)
      MODE_BOX: return CNTW'(ENTRIES_BOX - 1);
      MODE_ALL: return CNTW'(ENTRIES_ALL - 1);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/des_cfg_addr_gen.sv
// Cascaded column/row/S-box address counter for the loader's edit bus.
// Column wraps into row, row wraps into S-box only when the caller enables the carry.
module des_cfg_addr_gen
  import des_cfg_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [SW-1:0] load_sbox,
  input  logic [RW-1:0] load_row,
  input  logic [CW-1:0] load_col,
  input  logic          inc,
  input  logic          inc_sbox,
  output logic [SW-1:0] sbox,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          box_last
);

  logic col_last;

  assign col_last = (col == CW'(N_COL - 1));
  assign box_last = col_last && (row == RW'(N_ROW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbox <= '0;
      row  <= '0;
      col  <= '0;
    end else if (load) begin
      sbox <= load_sbox;
      row  <= load_row;
      col  <= load_col;
    end else if (inc) begin
      col <= col + CW'(1);
      if (col_last) begin
        row <= row + RW'(1);
      end
      if (inc_sbox) begin
        sbox <= sbox + SW'(1);
      end
    end
  end

endmodule

// File: rtl/des_sbox_cfg_loader.sv
// Streams 4-bit table entries onto the shared S-box edit bus in single-entry,
// one-box or all-box mode; every edit-bus output is registered (1-cycle write latency).
module des_sbox_cfg_loader
  import des_cfg_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] cfg_sbox,
  input  logic [RW-1:0] cfg_row,
  input  logic [CW-1:0] cfg_col,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          abort,
  output logic          s_ready,
  output logic          edit_sbox,
  output logic [DW-1:0] new_sbox_val,
  output logic [SW-1:0] sbox_sel,
  output logic [RW-1:0] row_sel,
  output logic [CW-1:0] col_sel,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t          state_reg, state_next;
  mode_t           mode_reg, mode_next;
  mode_t           start_mode;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [CNTW-1:0] last_reg, last_next;

  logic            edit_next, done_next, err_next;
  logic [DW-1:0]   val_next;
  logic [SW-1:0]   sbox_sel_next;
  logic [RW-1:0]   row_sel_next;
  logic [CW-1:0]   col_sel_next;

  logic            addr_load, addr_inc, inc_sbox, box_last;
  logic [SW-1:0]   load_sbox, cur_sbox;
  logic [RW-1:0]   load_row, cur_row;
  logic [CW-1:0]   load_col, cur_col;

  assign start_mode = mode_t'(mode);

  // Mode 2 always sweeps from the origin; mode 1 starts at the top-left of one box.
  always_comb begin
    load_sbox = cfg_sbox;
    load_row  = cfg_row;
    load_col  = cfg_col;
    if (start_mode == MODE_ALL) begin
      load_sbox = '0;
      load_row  = '0;
      load_col  = '0;
    end else if (start_mode == MODE_BOX) begin
      load_row  = '0;
      load_col  = '0;
    end
  end

  assign inc_sbox = box_last && (mode_reg == MODE_ALL);

  des_cfg_addr_gen u_addr (
    .clk       (clk),
    .rst       (rst),
    .load      (addr_load),
    .load_sbox (load_sbox),
    .load_row  (load_row),
    .load_col  (load_col),
    .inc       (addr_inc),
    .inc_sbox  (inc_sbox),
    .sbox      (cur_sbox),
    .row       (cur_row),
    .col       (cur_col),
    .box_last  (box_last)
  );

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    cnt_next      = cnt_reg;
    last_next     = last_reg;
    s_ready       = 1'b0;
    busy          = (state_reg != IDLE);
    addr_load     = 1'b0;
    addr_inc      = 1'b0;
    edit_next     = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    val_next      = new_sbox_val;
    sbox_sel_next = sbox_sel;
    row_sel_next  = row_sel;
    col_sel_next  = col_sel;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (start_mode == MODE_RSVD) begin
            err_next = 1'b1;
          end else begin
            mode_next  = start_mode;
            cnt_next   = '0;
            last_next  = last_index(start_mode);
            addr_load  = 1'b1;
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        // abort gates ready combinationally so nothing is accepted in the abort cycle.
        s_ready = !abort;
        if (abort) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (s_valid) begin
          edit_next     = 1'b1;
          val_next      = s_data;
          sbox_sel_next = cur_sbox;
          row_sel_next  = cur_row;
          col_sel_next  = cur_col;
          addr_inc      = 1'b1;
          cnt_next      = cnt_reg + CNTW'(1);
          if (cnt_reg == last_reg) begin
            state_next = FIN;
          end
        end
      end
      FIN: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_SINGLE;
      cnt_reg      <= '0;
      last_reg     <= '0;
      edit_sbox    <= 1'b0;
      new_sbox_val <= '0;
      sbox_sel     <= '0;
      row_sel      <= '0;
      col_sel      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      cnt_reg      <= cnt_next;
      last_reg     <= last_next;
      edit_sbox    <= edit_next;
      new_sbox_val <= val_next;
      sbox_sel     <= sbox_sel_next;
      row_sel      <= row_sel_next;
      col_sel      <= col_sel_next;
      done         <= done_next;
      err          <= err_next;
    end
  end

endmodule
